// File: rtl/axil_manager_bridge.sv
// Single-outstanding AXI4-Lite manager: turns a valid/ready register-access request
// into one AXI-Lite read or write and returns RDATA/RESP on a valid/ready response port.
module axil_manager_bridge #(
    parameter int         C_AXI_ADDR_WIDTH = 4,
    parameter logic [2:0] C_AXI_PROT       = 3'b000,
    localparam int        C_AXI_DATA_WIDTH = 32,
    localparam int        C_AXI_STRB_WIDTH = C_AXI_DATA_WIDTH / 8
) (
    input  logic                        M_AXI_ACLK,
    input  logic                        M_AXI_ARESET,

    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic                        i_req_write,
    input  logic [C_AXI_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0] i_req_data,
    input  logic [C_AXI_STRB_WIDTH-1:0] i_req_strb,

    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic                        o_rsp_write,
    output logic [C_AXI_DATA_WIDTH-1:0] o_rsp_data,
    output logic [1:0]                  o_rsp_resp,

    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                  M_AXI_AWPROT,

    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [C_AXI_STRB_WIDTH-1:0] M_AXI_WSTRB,

    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    input  logic [1:0]                  M_AXI_BRESP,

    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                  M_AXI_ARPROT,

    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t                      state;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
    logic                        aw_finish;
    logic                        w_finish;

    assign o_req_ready  = (state == IDLE);
    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_AWPROT = C_AXI_PROT;
    assign M_AXI_ARPROT = C_AXI_PROT;

    // A channel counts as finished if it already handshook earlier or handshakes now.
    assign aw_finish = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_finish  = !M_AXI_WVALID  || M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state         <= IDLE;
            addr_q        <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            o_rsp_valid   <= 1'b0;
            o_rsp_write   <= 1'b0;
            o_rsp_data    <= '0;
            o_rsp_resp    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        addr_q      <= i_req_addr;
                        M_AXI_WDATA <= i_req_data;
                        M_AXI_WSTRB <= i_req_strb;
                        o_rsp_write <= i_req_write;
                        if (i_req_write) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WR_ADDR_DATA;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if (aw_finish && w_finish) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        o_rsp_data   <= '0;
                        o_rsp_resp   <= M_AXI_BRESP;
                        o_rsp_valid  <= 1'b1;
                        state        <= RESP;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        o_rsp_data   <= M_AXI_RDATA;
                        o_rsp_resp   <= M_AXI_RRESP;
                        o_rsp_valid  <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_manager_bridge.sv
// Scoreboard bench for axil_manager_bridge: directed requests against a behavioural
// AXI-Lite subordinate with programmable stalls, plus AXI handshake rule checks.
module tb_axil_manager_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid = 1'b0, o_req_ready, i_req_write = 1'b0;
    logic [3:0]  i_req_addr = '0;
    logic [31:0] i_req_data = '0;
    logic [3:0]  i_req_strb = '0;
    logic        o_rsp_valid, i_rsp_ready = 1'b0, o_rsp_write;
    logic [31:0] o_rsp_data;
    logic [1:0]  o_rsp_resp;
    logic        M_AXI_AWVALID, M_AXI_AWREADY = 1'b0;
    logic [3:0]  M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_WVALID, M_AXI_WREADY = 1'b0;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_BVALID = 1'b0, M_AXI_BREADY;
    logic [1:0]  M_AXI_BRESP = '0;
    logic        M_AXI_ARVALID, M_AXI_ARREADY = 1'b0;
    logic [3:0]  M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_RVALID = 1'b0, M_AXI_RREADY;
    logic [31:0] M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_RRESP = '0;

    axil_manager_bridge #(.C_AXI_ADDR_WIDTH(4), .C_AXI_PROT(3'b000)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
        .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_strb(i_req_strb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
        .o_rsp_data(o_rsp_data), .o_rsp_resp(o_rsp_resp),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        write;
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;
    rsp_t exp_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    // Subordinate configuration and observation points
    int          aw_stall = 0, w_stall = 0, ar_stall = 0, b_stall = 1, r_stall = 1;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] mem [4];
    int          aw_edge, w_edge, b_edge, ar_edge, r_edge;
    int          aw_count = 0, b_count = 0, ar_count = 0, r_count = 0;
    int          acc_edge = 0, rsp_edge = 0, hs_edge = 0, rsp_hs_count = 0, rsp_hold = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Behavioural subordinate; evaluates just after each falling edge so READYs settle before the rising edge.
    initial begin : subordinate
        int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
        bit b_pend, r_pend, got_aw, got_w, aw_fire, w_fire, b_fire, ar_fire, r_fire;
        logic [3:0]  aw_addr_l, ar_addr_l, w_strb_l;
        logic [31:0] w_data_l;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
        {b_pend, r_pend, got_aw, got_w, aw_fire, w_fire, b_fire, ar_fire, r_fire} = '0;
        aw_addr_l = '0; ar_addr_l = '0; w_strb_l = '0; w_data_l = '0;
        mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'h0; mem[3] = 32'h1234_5678;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
                M_AXI_BVALID = 0; M_AXI_RVALID = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                {b_pend, r_pend, got_aw, got_w, aw_fire, w_fire, b_fire, ar_fire, r_fire} = '0;
                continue;
            end
            if (aw_fire) begin got_aw = 1; M_AXI_AWREADY = 0; aw_cnt = 0; aw_count++; end
            if (w_fire)  begin got_w = 1;  M_AXI_WREADY = 0;  w_cnt = 0; end
            if (got_aw && got_w) begin
                for (int i = 0; i < 4; i++)
                    if (w_strb_l[i]) mem[aw_addr_l[3:2]][8*i +: 8] = w_data_l[8*i +: 8];
                got_aw = 0; got_w = 0; b_pend = 1; b_wait = b_stall;
            end
            if (b_fire)  begin M_AXI_BVALID = 0; b_count++; end
            if (ar_fire) begin M_AXI_ARREADY = 0; ar_cnt = 0; ar_count++; r_pend = 1; r_wait = r_stall; end
            if (r_fire)  begin M_AXI_RVALID = 0; r_count++; end

            if (M_AXI_AWVALID && !M_AXI_AWREADY) begin
                if (aw_cnt >= aw_stall) M_AXI_AWREADY = 1; else aw_cnt++;
            end
            if (M_AXI_WVALID && !M_AXI_WREADY) begin
                if (w_cnt >= w_stall) M_AXI_WREADY = 1; else w_cnt++;
            end
            if (M_AXI_ARVALID && !M_AXI_ARREADY) begin
                if (ar_cnt >= ar_stall) M_AXI_ARREADY = 1; else ar_cnt++;
            end
            if (b_pend) begin
                if (b_wait == 0) begin M_AXI_BVALID = 1; M_AXI_BRESP = b_resp_cfg; b_pend = 0; end
                else b_wait--;
            end
            if (r_pend) begin
                if (r_wait == 0) begin
                    M_AXI_RVALID = 1; M_AXI_RDATA = mem[ar_addr_l[3:2]]; M_AXI_RRESP = r_resp_cfg; r_pend = 0;
                end else r_wait--;
            end

            aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
            w_fire  = M_AXI_WVALID && M_AXI_WREADY;
            b_fire  = M_AXI_BVALID && M_AXI_BREADY;
            ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
            r_fire  = M_AXI_RVALID && M_AXI_RREADY;
            if (aw_fire) begin aw_addr_l = M_AXI_AWADDR; aw_edge = cyc + 1; end
            if (w_fire)  begin w_data_l = M_AXI_WDATA; w_strb_l = M_AXI_WSTRB; w_edge = cyc + 1; end
            if (b_fire)  b_edge = cyc + 1;
            if (ar_fire) begin ar_addr_l = M_AXI_ARADDR; ar_edge = cyc + 1; end
            if (r_fire)  r_edge = cyc + 1;
        end
    end

    // AXI manager rules: VALID held with stable payload until its handshake, dropped right after it.
    initial begin : protocol_check
        logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        logic [3:0]  p_awaddr, p_araddr, p_wstrb;
        logic [31:0] p_wdata;
        {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} = '0;
        p_awaddr = '0; p_araddr = '0; p_wstrb = '0; p_wdata = '0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} = '0;
                continue;
            end
            if (p_awv && !p_awr) checkOutput("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, p_awaddr});
            if (p_awv && p_awr)  checkOutput("aw_drop", M_AXI_AWVALID, 0);
            if (p_wv && !p_wr)   checkOutput("w_hold", {M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB}, {1'b1, p_wdata, p_wstrb});
            if (p_wv && p_wr)    checkOutput("w_drop", M_AXI_WVALID, 0);
            if (p_arv && !p_arr) checkOutput("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, p_araddr});
            if (p_arv && p_arr)  checkOutput("ar_drop", M_AXI_ARVALID, 0);
            if ((p_awv && p_awr) || (p_arv && p_arr))
                checkOutput("outstanding_le1", ((aw_count - b_count) + (ar_count - r_count)) <= 1, 1);
            p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
            p_wv = M_AXI_WVALID; p_wr = M_AXI_WREADY; p_wdata = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
            p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
        end
    end

    // Response monitor: pops the scoreboard on each presented response, applies back-pressure.
    initial begin : rsp_monitor
        logic        m_pv, m_pr;
        logic [34:0] m_payload;
        int          hold_cnt;
        rsp_t        e;
        m_pv = 0; m_pr = 0; m_payload = '0; hold_cnt = 0;
        forever begin
            @(negedge clk); #3;
            if (rst) begin
                i_rsp_ready = 0; m_pv = 0; m_pr = 0; hold_cnt = 0;
                continue;
            end
            if (m_pv && m_pr) begin
                rsp_hs_count++;
                checkOutput("rsp_valid_drop", o_rsp_valid, 0);
                checkOutput("idle_after_rsp", o_req_ready, 1);
                i_rsp_ready = 0;
                hold_cnt = 0;
            end else if (o_rsp_valid) begin
                if (!m_pv) rsp_edge = cyc + 1;
                checkOutput("req_ready_busy", o_req_ready, 0);
                if (m_pv) checkOutput("rsp_stable", {o_rsp_write, o_rsp_data, o_rsp_resp}, m_payload);
                if (hold_cnt >= rsp_hold) begin
                    i_rsp_ready = 1;
                    hs_edge = cyc + 1;
                    if (exp_q.size() == 0) begin
                        tests_run++; tests_failed++;
                        $display("[TB] FAIL unexpected_rsp: got write=%0b data=0x%0h resp=%0d, required no response",
                                 o_rsp_write, o_rsp_data, o_rsp_resp);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("rsp_write", o_rsp_write, e.write);
                        checkOutput("rsp_data", o_rsp_data, e.data);
                        checkOutput("rsp_resp", o_rsp_resp, e.resp);
                    end
                end else begin
                    hold_cnt++;
                end
            end
            m_pv = o_rsp_valid; m_pr = i_rsp_ready; m_payload = {o_rsp_write, o_rsp_data, o_rsp_resp};
        end
    end

    task automatic applyStimulus(input bit write, input logic [3:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input bit expect_rsp,
                                 input logic [31:0] exp_data, input logic [1:0] exp_resp);
        rsp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!o_req_ready && n < 100) begin @(negedge clk); n++; end
        checkOutput("req_ready_idle", o_req_ready, 1);
        if (expect_rsp) begin
            e.write = write; e.data = exp_data; e.resp = exp_resp;
            exp_q.push_back(e);
        end
        i_req_write = write; i_req_addr = addr; i_req_data = data; i_req_strb = strb;
        i_req_valid = 1;
        acc_edge = cyc + 1;
        @(negedge clk);
        i_req_valid = 0;
        i_req_data = 32'hFFFF_FFFF;
        i_req_strb = 4'hF;
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && o_req_ready && !i_rsp_ready) return;
        end
        tests_run++; tests_failed++;
        $display("[TB] FAIL %s_timeout: %0d responses still pending, required 0", name, exp_q.size());
        exp_q.delete();
    endtask

    logic [3:0]  t6_addr [4];
    logic [31:0] t6_data [4];
    int          b_snap, hs_snap;

    initial begin : stimulus
        t6_addr[0] = 4'h8; t6_data[0] = 32'hA5A5_A5A5;
        t6_addr[1] = 4'h0; t6_data[1] = 32'h0F0F_0F0F;
        t6_addr[2] = 4'h4; t6_data[2] = 32'h5A5A_5A5A;
        t6_addr[3] = 4'hC; t6_data[3] = 32'hC3C3_C3C3;

        repeat (3) @(negedge clk);
        checkOutput("reset_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, o_rsp_valid}, 0);
        checkOutput("reset_req_ready", o_req_ready, 1);
        checkOutput("reset_payload", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, o_rsp_data, o_rsp_resp}, 0);
        checkOutput("prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
        rst = 0;

        // Minimum-latency write then read back
        applyStimulus(1, 4'h4, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, 2'b00);
        waitIdle("wr_min");
        checkOutput("wr_aw_lat", aw_edge - acc_edge, 1);
        checkOutput("wr_w_lat", w_edge - acc_edge, 1);
        checkOutput("wr_b_lat", b_edge - acc_edge, 3);
        checkOutput("wr_rsp_lat", rsp_edge - acc_edge, 4);
        checkOutput("wr_mem", mem[1], 32'hDEAD_BEEF);
        applyStimulus(0, 4'h4, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 2'b00);
        waitIdle("rd_min");
        checkOutput("rd_ar_lat", ar_edge - acc_edge, 1);
        checkOutput("rd_r_lat", r_edge - acc_edge, 3);
        checkOutput("rd_rsp_lat", rsp_edge - acc_edge, 4);

        // W accepted two cycles before AW; exactly one B consumed
        aw_stall = 2; b_snap = b_count;
        applyStimulus(1, 4'h0, 32'h1122_3344, 4'hF, 1, 32'h0, 2'b00);
        waitIdle("w_first");
        checkOutput("wfirst_w_lat", w_edge - acc_edge, 1);
        checkOutput("wfirst_aw_lat", aw_edge - acc_edge, 3);
        checkOutput("wfirst_one_b", b_count - b_snap, 1);
        aw_stall = 0;

        // Partial strobes with SLVERR passed through, then read back
        b_resp_cfg = 2'b10;
        applyStimulus(1, 4'h0, 32'hAABB_CCDD, 4'h5, 1, 32'h0, 2'b10);
        waitIdle("strb_wr");
        b_resp_cfg = 2'b00;
        applyStimulus(0, 4'h0, 32'h0, 4'h0, 1, 32'h11BB_33DD, 2'b00);
        waitIdle("strb_rd");

        // Read with three stall cycles on R and SLVERR
        r_stall = 3; r_resp_cfg = 2'b10;
        applyStimulus(0, 4'hC, 32'hCAFE_F00D, 4'hF, 1, 32'h1234_5678, 2'b10);
        waitIdle("rd_stall");
        checkOutput("rd_stall_r_lat", r_edge - acc_edge, 5);
        r_stall = 1;

        // Response back-pressure for five cycles, DECERR passed through
        rsp_hold = 5; r_resp_cfg = 2'b11;
        applyStimulus(0, 4'h4, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 2'b11);
        waitIdle("bp");
        checkOutput("bp_hs_lat", hs_edge - acc_edge, 9);
        rsp_hold = 0; r_resp_cfg = 2'b00;

        // Reset while AWVALID is pending and W already accepted
        aw_stall = 20; hs_snap = rsp_hs_count;
        applyStimulus(1, 4'h8, 32'h0000_0055, 4'hF, 0, 32'h0, 2'b00);
        @(negedge clk);
        checkOutput("pre_reset_aw_w", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b10);
        rst = 1;
        @(negedge clk);
        checkOutput("mid_reset_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, o_rsp_valid}, 0);
        checkOutput("mid_reset_req_ready", o_req_ready, 1);
        @(negedge clk);
        rst = 0; aw_stall = 0;
        repeat (20) @(negedge clk);
        checkOutput("no_rsp_after_reset", rsp_hs_count - hs_snap, 0);
        checkOutput("no_write_after_reset", mem[2], 32'h0);

        // Write/read pairs under random subordinate stalls
        for (int k = 0; k < 4; k++) begin
            aw_stall = $urandom_range(0, 3); w_stall = $urandom_range(0, 3);
            b_stall = $urandom_range(0, 3);
            applyStimulus(1, t6_addr[k], t6_data[k], 4'hF, 1, 32'h0, 2'b00);
            ar_stall = $urandom_range(0, 3); r_stall = $urandom_range(0, 3);
            rsp_hold = $urandom_range(0, 2);
            applyStimulus(0, t6_addr[k], 32'h0, 4'h0, 1, t6_data[k], 2'b00);
            waitIdle("rand_pair");
        end
        rsp_hold = 0;

        checkOutput("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
